// File: rtl/tc_pl_gain_pkg.sv
// Shared constants, state encoding and helpers for the multi-channel gain DAC loader.
package tc_pl_gain_pkg;

  localparam logic [3:0] CMD_WR_UPD = 4'h3;
  localparam int         CH_ADDR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_LDAC,
    ST_DONE
  } gain_state_t;

  // Command nibble + address nibble + code.
  function automatic int frame_w(input int data_w);
    return 8 + data_w;
  endfunction

endpackage

// File: rtl/tc_pl_gain_spi_tx.sv
// Serialises one SPI frame (mode 0, MSB first) and then holds CSN high for the
// inter-frame gap. start is honoured only when idle; frame_done marks the last
// cycle of the final SCK high phase, gap_done marks the last gap cycle.
module tc_pl_gain_spi_tx #(
  parameter int FRAME_W = 24,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               frame_done,
  output logic               gap_done,
  output logic               sdi,
  output logic               sck,
  output logic               csn
);

  localparam int BIT_W = $clog2(FRAME_W);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_GAP} tx_phase_t;

  tx_phase_t          phase;
  logic [FRAME_W-2:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  assign frame_done = (phase == TX_SHIFT) && sck && (div_cnt == '0) && (bit_cnt == '0);
  assign gap_done   = (phase == TX_GAP) && (gap_cnt == '0);

  // Load / shift / gap sequencing; SDI only moves on the SCK falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= TX_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      sdi     <= 1'b0;
      sck     <= 1'b0;
      csn     <= 1'b1;
    end else begin
      case (phase)
        TX_IDLE: begin
          if (start) begin
            phase   <= TX_LOAD;
            csn     <= 1'b0;
            sdi     <= frame[FRAME_W-1];
            shreg   <= frame[FRAME_W-2:0];
            bit_cnt <= BIT_W'(FRAME_W - 1);
            div_cnt <= DIV_W'(CLK_DIV - 1);
          end
        end
        TX_LOAD: phase <= TX_SHIFT;
        TX_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
            if (!sck) begin
              sck <= 1'b1;
            end else if (bit_cnt == '0) begin
              sck     <= 1'b0;
              csn     <= 1'b1;
              sdi     <= 1'b0;
              phase   <= TX_GAP;
              gap_cnt <= GAP_W'(CS_GAP - 1);
            end else begin
              sck     <= 1'b0;
              sdi     <= shreg[FRAME_W-2];
              shreg   <= {shreg[FRAME_W-3:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        TX_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          else               phase   <= TX_IDLE;
        end
        default: phase <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tc_pl_cap_gain_dac_mc.sv
// Multi-channel capture-gain DAC loader: latches N_CH codes, sends one
// write-and-update frame per channel (optionally only changed ones), then
// strobes LDACN and pulses completion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for gset_en
// SCAN     | decide send/skip for channel ch
// LOAD     | CSN low, frame MSB on SDI
// SHIFT    | clocking frame bits out
// GAP      | CSN high between frames
// LDAC     | LDACN held low after the last frame
// DONE     | one-cycle completion pulse
module tc_pl_cap_gain_dac_mc
  import tc_pl_gain_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4,
  parameter int LDAC_EN = 1,
  parameter int LDAC_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gset_en,
  input  logic                   gset_mode,
  input  logic [N_CH*DATA_W-1:0] gset_data,
  output logic                   gset_busy,
  output logic                   gset_adc_cmpt,
  output logic [4:0]             gset_wr_cnt,
  output logic                   DAC0_SDI,
  output logic                   DAC0_SCK,
  output logic                   DAC0_CSN,
  output logic                   DAC0_LDACN
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int N_SLOT  = 2 ** IDX_W;
  localparam int LDAC_CW = $clog2(LDAC_W + 1);

  gain_state_t        state, state_next;
  logic [IDX_W-1:0]   ch;
  logic [4:0]         wr_cnt;
  logic               mode_q;
  logic [DATA_W-1:0]  codes      [N_SLOT];
  logic [DATA_W-1:0]  cache_code [N_SLOT];
  logic [N_SLOT-1:0]  cache_vld;
  logic [LDAC_CW-1:0] ldac_cnt;
  logic               ldacn_q;

  logic               tx_start, ch_inc, frame_done, gap_done;
  logic               send, last_ch, go_ldac;
  logic [DATA_W-1:0]  cur_code;

  assign cur_code = codes[ch];
  assign send     = !mode_q || !cache_vld[ch] || (cache_code[ch] != cur_code);
  assign last_ch  = (ch == IDX_W'(N_CH - 1));
  assign go_ldac  = (wr_cnt != '0) && (LDAC_EN != 0);

  assign gset_busy     = (state != ST_IDLE);
  assign gset_adc_cmpt = (state == ST_DONE);
  assign DAC0_LDACN    = ldacn_q;

  tc_pl_gain_spi_tx #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (tx_start),
    .frame      ({CMD_WR_UPD, CH_ADDR_W'(ch), cur_code}),
    .frame_done (frame_done),
    .gap_done   (gap_done),
    .sdi        (DAC0_SDI),
    .sck        (DAC0_SCK),
    .csn        (DAC0_CSN)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; tx is kicked from SCAN so CSN falls entering LOAD.
  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    ch_inc     = 1'b0;
    case (state)
      ST_IDLE: if (gset_en) state_next = ST_SCAN;
      ST_SCAN: begin
        if (send) begin
          state_next = ST_LOAD;
          tx_start   = 1'b1;
        end else if (last_ch) begin
          state_next = go_ldac ? ST_LDAC : ST_DONE;
        end else begin
          ch_inc = 1'b1;
        end
      end
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_next = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
          if (last_ch) begin
            state_next = go_ldac ? ST_LDAC : ST_DONE;
          end else begin
            state_next = ST_SCAN;
            ch_inc     = 1'b1;
          end
        end
      end
      ST_LDAC:  if (ldac_cnt == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request latch, channel walk, cache update on completed frames, result count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch          <= '0;
      wr_cnt      <= '0;
      gset_wr_cnt <= '0;
      mode_q      <= 1'b0;
      cache_vld   <= '0;
      for (int k = 0; k < N_SLOT; k++) begin
        codes[k]      <= '0;
        cache_code[k] <= '0;
      end
    end else begin
      if (state == ST_IDLE && gset_en) begin
        mode_q <= gset_mode;
        ch     <= '0;
        wr_cnt <= '0;
        for (int k = 0; k < N_CH; k++) codes[k] <= gset_data[k*DATA_W +: DATA_W];
      end
      if (ch_inc) ch <= ch + 1'b1;
      if (state == ST_SHIFT && frame_done) begin
        cache_code[ch] <= cur_code;
        cache_vld[ch]  <= 1'b1;
        wr_cnt         <= wr_cnt + 1'b1;
      end
      if (state_next == ST_DONE && state != ST_DONE) gset_wr_cnt <= wr_cnt;
    end
  end

  // LDACN is registered so the pin is glitch-free; low exactly while in LDAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      ldac_cnt <= '0;
      ldacn_q  <= 1'b1;
    end else begin
      ldacn_q <= (state_next != ST_LDAC);
      if (state != ST_LDAC)      ldac_cnt <= LDAC_CW'(LDAC_W - 1);
      else if (ldac_cnt != '0)   ldac_cnt <= ldac_cnt - 1'b1;
    end
  end

endmodule
